pll_drp_ctrl: RTL and testbench

PLL_DRP_CTRL -- requirements
Module: pll_drp_ctrl

---
 rtl/pll_drp_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pll_drp_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_drp_ctrl.sv
// PLL DRP reconfiguration controller: holds the PLL in reset, applies a table of
// read-modify-write DRP updates, then releases reset and waits for lock.
module pll_drp_ctrl #(
  parameter int NUM_MAX      = 8,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic        DCLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        CFG_WE,
  input  logic [2:0]  CFG_IDX,
  input  logic [6:0]  CFG_ADDR,
  input  logic [15:0] CFG_MASK,
  input  logic [15:0] CFG_DATA,
  input  logic [3:0]  CFG_NUM,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY,
  output logic        PLL_RST,
  input  logic        LOCKED,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  localparam int TMAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] DRDY_LAST = TW'(DRDY_TIMEOUT - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]    NUM_CAP   = 4'(NUM_MAX);

  typedef enum logic [2:0] {
    IDLE, ASSERT_RST, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RELEASE, WAIT_LOCK
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   doCap_q, doCap_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  logic [6:0]    tblAddr_q [8];
  logic [15:0]   tblMask_q [8];
  logic [15:0]   tblData_q [8];

  logic          tblWe;
  logic [TW-1:0] timerInc;
  logic          reqState;

  assign tblWe    = CFG_WE && (state_q == IDLE) && ({1'b0, CFG_IDX} < NUM_CAP);
  assign timerInc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

  always_ff @(posedge DCLK) begin
    if (!RST_N) begin
      for (int i = 0; i < 8; i++) begin
        tblAddr_q[i] <= '0;
        tblMask_q[i] <= '0;
        tblData_q[i] <= '0;
      end
    end else if (tblWe) begin
      tblAddr_q[CFG_IDX] <= CFG_ADDR;
      tblMask_q[CFG_IDX] <= CFG_MASK;
      tblData_q[CFG_IDX] <= CFG_DATA;
    end
  end

  always_ff @(posedge DCLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      count_q <= '0;
      timer_q <= '0;
      doCap_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      timer_q <= timer_d;
      doCap_q <= doCap_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // The timer is zeroed by the state that hands over to each wait state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    timer_d = timer_q;
    doCap_d = doCap_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START && !done_q) begin
          count_d = (CFG_NUM > NUM_CAP) ? NUM_CAP : CFG_NUM;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = ASSERT_RST;
        end
      end
      ASSERT_RST: state_d = (count_q == 4'd0) ? RELEASE : RD_REQ;
      RD_REQ: begin
        timer_d = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (DRDY) begin
          doCap_d = DO;
          state_d = WR_REQ;
        end else if (timer_q >= DRDY_LAST) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end else begin
          timer_d = timerInc;
        end
      end
      WR_REQ: begin
        timer_d = '0;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (DRDY) begin
          if (({1'b0, idx_q} + 4'd1) < count_q) begin
            idx_d   = idx_q + 3'd1;
            state_d = RD_REQ;
          end else begin
            state_d = RELEASE;
          end
        end else if (timer_q >= DRDY_LAST) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end else begin
          timer_d = timerInc;
        end
      end
      RELEASE: begin
        timer_d = '0;
        state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (LOCKED) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (timer_q >= LOCK_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timerInc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign reqState = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign DEN      = reqState;
  assign DWE      = (state_q == WR_REQ);
  assign DADDR    = reqState ? tblAddr_q[idx_q] : '0;
  assign DI       = (state_q == WR_REQ)
                  ? ((doCap_q & tblMask_q[idx_q]) | (tblData_q[idx_q] & ~tblMask_q[idx_q]))
                  : '0;
  assign PLL_RST  = (state_q == ASSERT_RST) || (state_q == RD_REQ) || (state_q == RD_WAIT)
                 || (state_q == WR_REQ) || (state_q == WR_WAIT);
  assign BUSY     = (state_q != IDLE);
  assign DONE     = done_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Bench for pll_drp_ctrl: each run is planned as an expected cycle timeline from
// the table contents, responder latencies and lock delay, then replayed and compared.
module tb_pll_drp_ctrl;

  localparam int NUM_MAX = 6;
  localparam int DRDY_TO = 64;
  localparam int LOCK_TO = 100;

  localparam int T_IDLE = 0, T_ASSERT = 1, T_RDREQ = 2, T_RDWAIT = 3, T_WRREQ = 4;
  localparam int T_WRWAIT = 5, T_REL = 6, T_WLOCK = 7, T_DONE = 8;

  logic        DCLK = 1'b0;
  logic        RST_N, START, CFG_WE, DEN, DWE, DRDY, PLL_RST, LOCKED, BUSY, DONE, ERR;
  logic [2:0]  CFG_IDX;
  logic [6:0]  CFG_ADDR, DADDR;
  logic [15:0] CFG_MASK, CFG_DATA, DI, DO;
  logic [3:0]  CFG_NUM;

  always #5 DCLK = ~DCLK;

  pll_drp_ctrl #(.NUM_MAX(NUM_MAX), .DRDY_TIMEOUT(DRDY_TO), .LOCK_TIMEOUT(LOCK_TO)) dut (
    .DCLK(DCLK), .RST_N(RST_N), .START(START), .CFG_WE(CFG_WE), .CFG_IDX(CFG_IDX),
    .CFG_ADDR(CFG_ADDR), .CFG_MASK(CFG_MASK), .CFG_DATA(CFG_DATA), .CFG_NUM(CFG_NUM),
    .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI), .DO(DO), .DRDY(DRDY),
    .PLL_RST(PLL_RST), .LOCKED(LOCKED), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  // One entry per clock: inputs driven for that cycle and the outputs expected in it.
  typedef struct {
    bit start; bit [3:0] num; bit we; bit [2:0] widx; bit [6:0] wa; bit [15:0] wm; bit [15:0] wd;
    bit drdy; bit [15:0] dout; bit locked; bit rstN; bit chk; bit [28:0] exp; int tag;
  } cycT;

  cycT         q[$];
  int          total = 0, bad = 0, noisePct = 15;
  bit [6:0]    tblA[8];
  bit [15:0]   tblM[8], tblD[8];
  bit          modelErr, forceBusyWe;
  int          planRd[8], planWr[8];
  bit [15:0]   planDo[8];
  int          denCnt, relCnt, doneCnt, pllCnt, cycNo;
  bit [15:0]   lastDi;
  bit [6:0]    addrSeq[$];
  bit          dweSeq[$];

  function automatic string tagName(int t);
    case (t)
      T_IDLE: return "IDLE";     T_ASSERT: return "ASSERT"; T_RDREQ: return "RDREQ";
      T_RDWAIT: return "RDWAIT"; T_WRREQ: return "WRREQ";   T_WRWAIT: return "WRWAIT";
      T_REL: return "RELEASE";   T_WLOCK: return "WAITLOCK"; default: return "DONE";
    endcase
  endfunction

  function automatic cycT mkCyc(int tag, bit busy, bit pll, bit den, bit dwe, bit [6:0] a,
                                bit [15:0] di, bit done);
    cycT c;
    c = '{default: '0};
    c.tag = tag; c.rstN = 1'b1; c.chk = 1'b1; c.dout = 16'($urandom);
    c.exp = {a, den, dwe, di, pll, busy, done, modelErr};
    return c;
  endfunction

  // Inputs the DUT must ignore in the state it is in when they are sampled.
  function automatic cycT noisy(cycT cin, bit dr, bit lk, bit ctl);
    cycT c = cin;
    if (dr) c.drdy = ($urandom_range(3) == 0);
    if (lk) c.locked = ($urandom_range(3) == 0);
    if (ctl && $urandom_range(99) < noisePct) begin
      c.start = 1'b1; c.num = 4'($urandom_range(15));
    end
    if (ctl && $urandom_range(99) < noisePct) begin
      c.we = 1'b1; c.widx = 3'($urandom_range(7)); c.wa = 7'($urandom);
      c.wm = 16'($urandom); c.wd = 16'($urandom);
    end
    return c;
  endfunction

  task automatic checkOutput(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic applyStimulus();
    cycT c;
    logic [28:0] got;
    denCnt = 0; relCnt = 0; doneCnt = 0; pllCnt = 0; lastDi = '0;
    addrSeq.delete(); dweSeq.delete();
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge DCLK);
      cycNo++;
      got = {DADDR, DEN, DWE, DI, PLL_RST, BUSY, DONE, ERR};
      if (c.chk) begin
        checkOutput($sformatf("cyc%0d %s {daddr,den,dwe,di,pll,busy,done,err}", cycNo,
                    tagName(c.tag)), 32'(got), 32'(c.exp));
        if (DEN === 1'b1) begin
          denCnt++; addrSeq.push_back(DADDR); dweSeq.push_back(DWE);
          if (DWE === 1'b1) lastDi = DI;
        end
        if (BUSY === 1'b1 && PLL_RST === 1'b0) relCnt++;
        if (DONE === 1'b1) doneCnt++;
        if (PLL_RST === 1'b1) pllCnt++;
      end
      START = c.start; CFG_NUM = c.num; CFG_WE = c.we; CFG_IDX = c.widx;
      CFG_ADDR = c.wa; CFG_MASK = c.wm; CFG_DATA = c.wd;
      DRDY = c.drdy; DO = c.dout; LOCKED = c.locked; RST_N = c.rstN;
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 8; i++) begin
      tblA[i] = '0; tblM[i] = '0; tblD[i] = '0;
    end
    modelErr = 1'b0;
  endtask

  task automatic planIdle(int n);
    for (int i = 0; i < n; i++) q.push_back(noisy(mkCyc(T_IDLE, 0, 0, 0, 0, 0, 0, 0), 1, 1, 0));
  endtask

  task automatic planWrite(int idx, bit [6:0] a, bit [15:0] m, bit [15:0] d);
    cycT c;
    c = noisy(mkCyc(T_IDLE, 0, 0, 0, 0, 0, 0, 0), 1, 1, 0);
    c.we = 1'b1; c.widx = 3'(idx); c.wa = a; c.wm = m; c.wd = d;
    q.push_back(c);
    if (idx < NUM_MAX) begin
      tblA[idx] = a; tblM[idx] = m; tblD[idx] = d;
    end
  endtask

  task automatic planHang(int tag);
    for (int i = 0; i < DRDY_TO; i++) q.push_back(noisy(mkCyc(tag, 1, 1, 0, 0, 0, 0, 0), 0, 1, 1));
    modelErr = 1'b1;
  endtask

  // hangIdx/hangWr: entry whose read or write never gets DRDY; lockDelay 0 = never locks;
  // abortIdx: reset is applied in the first write-wait cycle of that entry.
  task automatic planRun(int num, int hangIdx, bit hangWr, int lockDelay, bit startOnDone,
                         int abortIdx);
    cycT c;
    int cnt;
    bit stop;
    bit [15:0] v;
    c = noisy(mkCyc(T_IDLE, 0, 0, 0, 0, 0, 0, 0), 1, 1, 0);
    c.start = 1'b1; c.num = 4'(num);
    q.push_back(c);
    cnt = (num > NUM_MAX) ? NUM_MAX : num;
    modelErr = 1'b0;
    stop = 1'b0;
    c = noisy(mkCyc(T_ASSERT, 1, 1, 0, 0, 0, 0, 0), 1, 1, 1);
    if (forceBusyWe) begin
      c.start = 1'b1; c.num = 4'd2; c.we = 1'b1; c.widx = 3'd0; c.wa = 7'h7F;
      c.wm = 16'h0000; c.wd = 16'hDEAD;
    end
    q.push_back(c);
    for (int k = 0; k < cnt && !stop; k++) begin
      q.push_back(noisy(mkCyc(T_RDREQ, 1, 1, 1, 0, tblA[k], 0, 0), 1, 1, 1));
      if (hangIdx == k && !hangWr) begin
        planHang(T_RDWAIT); stop = 1'b1;
      end else begin
        v = planDo[k];
        for (int i = 0; i < planRd[k]; i++) begin
          c = noisy(mkCyc(T_RDWAIT, 1, 1, 0, 0, 0, 0, 0), 0, 1, 1);
          c.drdy = (i == planRd[k] - 1);
          if (c.drdy) c.dout = v;
          q.push_back(c);
        end
        q.push_back(noisy(mkCyc(T_WRREQ, 1, 1, 1, 1, tblA[k],
                                (v & tblM[k]) | (tblD[k] & ~tblM[k]), 0), 1, 1, 1));
        if (abortIdx == k) begin
          c = mkCyc(T_WRWAIT, 1, 1, 0, 0, 0, 0, 0);
          c.rstN = 1'b0;
          q.push_back(c);
          clearModel();
          planIdle(2);
          return;
        end
        if (hangIdx == k && hangWr) begin
          planHang(T_WRWAIT); stop = 1'b1;
        end else begin
          for (int i = 0; i < planWr[k]; i++) begin
            c = noisy(mkCyc(T_WRWAIT, 1, 1, 0, 0, 0, 0, 0), 0, 1, 1);
            c.drdy = (i == planWr[k] - 1);
            q.push_back(c);
          end
        end
      end
    end
    q.push_back(noisy(mkCyc(T_REL, 1, 0, 0, 0, 0, 0, 0), 1, 1, 1));
    if (lockDelay > 0) begin
      for (int i = 0; i < lockDelay; i++) begin
        c = noisy(mkCyc(T_WLOCK, 1, 0, 0, 0, 0, 0, 0), 1, 0, 1);
        c.locked = (i == lockDelay - 1);
        q.push_back(c);
      end
    end else begin
      for (int i = 0; i < LOCK_TO; i++) q.push_back(noisy(mkCyc(T_WLOCK, 1, 0, 0, 0, 0, 0, 0), 1, 0, 1));
      modelErr = 1'b1;
    end
    c = noisy(mkCyc(T_DONE, 0, 0, 0, 0, 0, 0, 1), 1, 1, 0);
    if (startOnDone) begin
      c.start = 1'b1; c.num = 4'($urandom_range(6, 1));
    end
    q.push_back(c);
    planIdle(2);
  endtask

  task automatic setLatencies(int rd, int wr);
    for (int i = 0; i < 8; i++) begin
      planRd[i] = rd; planWr[i] = wr; planDo[i] = 16'($urandom);
    end
  endtask

  initial begin
    bit [6:0] expA[6];
    int hang;
    RST_N = 1'b0; START = 1'b0; CFG_WE = 1'b0; CFG_IDX = '0; CFG_ADDR = '0; CFG_MASK = '0;
    CFG_DATA = '0; CFG_NUM = '0; DRDY = 1'b0; DO = '0; LOCKED = 1'b0;
    cycNo = 0; forceBusyWe = 1'b0;
    clearModel();
    for (int i = 0; i < 3; i++) begin
      q.push_back(mkCyc(T_IDLE, 0, 0, 0, 0, 0, 0, 0));
      q[$].rstN = 1'b0;
    end
    planIdle(2);
    applyStimulus();

    // Single-entry read-modify-write with hand-computed merge result.
    setLatencies(2, 3);
    planWrite(0, 7'h08, 16'hF000, 16'h0145);
    planDo[0] = 16'hA3C7;
    planRun(1, -1, 0, 10, 0, -1);
    applyStimulus();
    checkOutput("r1 write DI", 32'(lastDi), 32'h0000A145);
    checkOutput("r1 DEN pulses", 32'(denCnt), 32'd2);
    checkOutput("r1 released+lock cycles", 32'(relCnt), 32'd11);
    checkOutput("r1 DONE pulses", 32'(doneCnt), 32'd1);
    checkOutput("r1 ERR at end", 32'(ERR), 32'd0);

    // Three entries in order, with a write to entry 0 and a START landing while busy.
    planWrite(1, 7'h09, 16'h00FF, 16'h1200);
    planWrite(2, 7'h14, 16'hFFFF, 16'h0000);
    setLatencies(3, 2);
    forceBusyWe = 1'b1;
    planRun(3, -1, 0, 4, 1, -1);
    forceBusyWe = 1'b0;
    applyStimulus();
    checkOutput("r2 DEN pulses", 32'(denCnt), 32'd6);
    expA = '{7'h08, 7'h08, 7'h09, 7'h09, 7'h14, 7'h14};
    for (int i = 0; i < 6 && i < addrSeq.size(); i++) begin
      checkOutput($sformatf("r2 DADDR #%0d", i), 32'(addrSeq[i]), 32'(expA[i]));
      checkOutput($sformatf("r2 DWE #%0d", i), 32'(dweSeq[i]), 32'(i % 2));
    end

    // Read of entry 1 never answered.
    setLatencies(1, 1);
    planRun(3, 1, 0, 5, 0, -1);
    applyStimulus();
    checkOutput("r3 DEN pulses", 32'(denCnt), 32'd3);
    checkOutput("r3 first DADDR kept", 32'(addrSeq.size() > 0 ? addrSeq[0] : 7'h00), 32'h08);
    checkOutput("r3 ERR sticky", 32'(ERR), 32'd1);
    checkOutput("r3 DONE pulses", 32'(doneCnt), 32'd1);

    // Lock never arrives.
    planRun(1, -1, 0, 0, 0, -1);
    applyStimulus();
    checkOutput("r4 released+lock cycles", 32'(relCnt), 32'd101);
    checkOutput("r4 ERR", 32'(ERR), 32'd1);

    // Zero-length table: reset pulse only.
    planRun(0, -1, 0, 3, 0, -1);
    applyStimulus();
    checkOutput("r5 DEN pulses", 32'(denCnt), 32'd0);
    checkOutput("r5 PLL_RST cycles", 32'(pllCnt), 32'd1);
    checkOutput("r5 ERR cleared by START", 32'(ERR), 32'd0);

    // Reset during a write wait, then a run on the cleared table.
    setLatencies(2, 2);
    planRun(3, -1, 0, 3, 0, 1);
    applyStimulus();
    checkOutput("r6 BUSY after reset", 32'(BUSY), 32'd0);
    planRun(2, -1, 0, 3, 0, -1);
    applyStimulus();
    checkOutput("r7 DEN pulses", 32'(denCnt), 32'd4);
    checkOutput("r7 cleared DI", 32'(lastDi), 32'd0);

    // Randomized runs.
    for (int r = 0; r < 30; r++) begin
      for (int w = 0; w < int'($urandom_range(4)); w++)
        planWrite($urandom_range(7), 7'($urandom), 16'($urandom), 16'($urandom));
      for (int i = 0; i < 8; i++) begin
        planRd[i] = $urandom_range(4, 1); planWr[i] = $urandom_range(4, 1);
        planDo[i] = 16'($urandom);
      end
      CFG_NUM = CFG_NUM;
      hang = ($urandom_range(5) == 0) ? int'($urandom_range(NUM_MAX - 1)) : -1;
      planRun($urandom_range(15), hang, 1'($urandom_range(1)),
              ($urandom_range(7) == 0) ? 0 : int'($urandom_range(12, 1)),
              1'($urandom_range(1)), ($urandom_range(11) == 0) ? 0 : -1);
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
